// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes, default width
// and the bit-counter width helper.
package serial_adder_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell driven one bit per cycle by serial_adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder controller: one full_adder cell, LSB first, WIDTH cycles per op.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .c_in (carry),
        .sum  (fa_sum),
        .c_out(fa_cout)
    );

    // Shift form avoids a [WIDTH-1:1] slice, which is empty when WIDTH == 1.
    assign sum_next  = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= c_in;
                        cnt    <= '0;
                        sum_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= sum_next;
                        c_out <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB on this edge
                        ovf   <= carry ^ fa_cout;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH 4, 1 and 8.
// Define SERIAL_ADDER_OVF_EN to also check the overflow output.
module tb_serial_adder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic       iv, rdy, ov, ordy, ci, co;
    logic [3:0] a, b, s;
    logic       iv1, rdy1, ov1, ordy1, a1, b1, c1, s1, co1;
    logic       iv8, rdy8, ov8, ordy8, c8, co8;
    logic [7:0] a8, b8, s8;
`ifdef SERIAL_ADDER_OVF_EN
    logic ovf, ovf1, ovf8;
`endif

    serial_adder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy), .a(a), .b(b), .c_in(ci),
        .out_valid(ov), .out_ready(ordy), .sum(s), .c_out(co)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .a(a1), .b(b1), .c_in(c1),
        .out_valid(ov1), .out_ready(ordy1), .sum(s1), .c_out(co1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8), .c_in(c8),
        .out_valid(ov8), .out_ready(ordy8), .sum(s8), .c_out(co8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full WIDTH=4 transaction with immediate out_ready; result values are hand-computed by the caller.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                          input logic [3:0] es, input logic ec);
        int n;
        chk("ready_before_accept", rdy, 1);
        a = ta; b = tb; ci = tc; iv = 1'b1; ordy = 1'b1;
        step();
        iv = 1'b0;
        n = 0;
        while (ov !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("latency", n, 4);
        chk("sum", s, es);
        chk("c_out", co, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf, (ta[3] ~^ tb[3]) & (es[3] ^ ta[3]));
`endif
        step();
        chk("done_to_idle", ov, 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] e8;
        int         n;

        checks = 0; errors = 0;
        rst = 1'b1;
        iv = 0; a = 0; b = 0; ci = 0; ordy = 0;
        iv1 = 0; a1 = 0; b1 = 0; c1 = 0; ordy1 = 1;
        iv8 = 0; a8 = 0; b8 = 0; c8 = 0; ordy8 = 1;

        step();
        step();
        chk("rst_in_ready", rdy, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_sum", s, 0);
        chk("rst_c_out", co, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        #1;
        chk("idle_in_ready", rdy, 1);

        // 5 + 3 with 5 cycles of backpressure
        a = 4'h5; b = 4'h3; ci = 0; iv = 1;
        step();
        iv = 0;
        chk("run_in_ready", rdy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("early_out_valid", ov, 0);
        end
        step();
        chk("op1_out_valid", ov, 1);
        chk("op1_sum", s, 4'h8);
        chk("op1_c_out", co, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("op1_ovf", ovf, 1);
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", ov, 1);
            chk("bp_sum", s, 4'h8);
            chk("bp_c_out", co, 0);
            chk("bp_in_ready", rdy, 0);
        end
        ordy = 1;
        step();
        chk("hs_out_valid", ov, 0);
        chk("hs_in_ready", rdy, 1);
        chk("hs_sum_held", s, 4'h8);

        run_op(4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
        run_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1);

        // operands captured at accept; later changes ignored (6+7+1 = 14)
        ordy = 0;
        a = 4'h6; b = 4'h7; ci = 1; iv = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            a = a ^ 4'hF; b = b ^ 4'hF; ci = ~ci;
            step();
        end
        chk("chg_out_valid", ov, 1);
        chk("chg_sum", s, 4'hE);
        chk("chg_c_out", co, 0);
        iv = 0; ordy = 1;
        step();
        chk("chg_idle", ov, 0);

        // reset asserted on the second RUN edge
        a = 4'h9; b = 4'h9; ci = 0; iv = 1;
        step();
        iv = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("abort_out_valid", ov, 0);
        chk("abort_sum", s, 0);
        chk("abort_c_out", co, 0);
        chk("abort_in_ready", rdy, 1);
        run_op(4'h2, 4'h2, 1'b0, 4'h4, 1'b0);

        // WIDTH=1: RUN lasts a single edge
        chk("w1_in_ready", rdy1, 1);
        a1 = 1; b1 = 1; c1 = 1; iv1 = 1;
        step();
        iv1 = 0;
        step();
        chk("w1_out_valid", ov1, 1);
        chk("w1_sum", s1, 1);
        chk("w1_c_out", co1, 1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("w1_ovf", ovf1, 0);
`endif
        step();
        chk("w1_idle", ov1, 0);

        // WIDTH=8 random operands against a + b + c_in
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            e8 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            a8 = ra; b8 = rb; c8 = rc; iv8 = 1;
            step();
            iv8 = 0;
            n = 0;
            while (ov8 !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            chk("w8_latency", n, 8);
            chk("w8_result", {co8, s8}, e8);
`ifdef SERIAL_ADDER_OVF_EN
            chk("w8_ovf", ovf8, (ra[7] ~^ rb[7]) & (e8[7] ^ ra[7]));
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
